uart_core: RTL and testbench

UART_CORE -- requirements
Module: uart_core

---
 rtl/uart_core.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// uart_core: TX FIFO + UART transmitter and a two-flop synchronised UART receiver.
// Optional parity support is compiled in with `define UART_CORE_PARITY_EN;
// without it PARITY is ignored, neither FSM has a PAR state and rx_parity_err is 0.
module uart_core #(
  parameter int CLK_HZ    = 100000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int TX_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(TX_DEPTH);
  localparam int BW  = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_CORE_PARITY_EN
    PAR,
`endif
    STOP
  } state_e;

`ifdef UART_CORE_PARITY_EN
  localparam bit PAR_EN = (PARITY != 0);

  // Even parity is the XOR of the payload; odd parity is its inverse.
  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction
`endif

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] mem_q [TX_DEPTH];
  logic [AW:0]          wr_q, rd_q;
  logic                 full, empty, push, pop;

  assign full     = (wr_q - rd_q) == (AW+1)'(TX_DEPTH);
  assign empty    = (wr_q == rd_q);
  assign tx_ready = !full;
  assign push     = tx_valid && !full;

  // FIFO pointers and storage; payload storage needs no reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q[AW-1:0]] <= tx_data;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  state_e               tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_q, tx_d, tx_tick;

  assign tx_tick = (tx_cnt_q == CW'(DIV - 1));
  assign tx      = tx_q;
  assign tx_busy = !empty || (tx_state_q != IDLE);

  // TX state register; reset drives the line high and aborts any frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
    end
    tx_sh_q <= tx_sh_d;
  end

  // TX next state: each bit held DIV clocks, back-to-back frames without idle gap.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_tick ? '0 : tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    case (tx_state_q)
      IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          tx_sh_d    = mem_q[rd_q[AW-1:0]];
          tx_state_d = START;
          tx_d       = 1'b0;
        end
      end
      START: if (tx_tick) begin
        tx_state_d = DATA;
        tx_bit_d   = '0;
        tx_d       = tx_sh_q[0];
      end
      DATA: if (tx_tick) begin
        if (tx_bit_q == BW'(DATA_BITS - 1)) begin
          tx_bit_d = '0;
`ifdef UART_CORE_PARITY_EN
          if (PAR_EN) begin
            tx_state_d = PAR;
            tx_d       = par_bit(tx_sh_q);
          end else begin
            tx_state_d = STOP;
            tx_d       = 1'b1;
          end
`else
          tx_state_d = STOP;
          tx_d       = 1'b1;
`endif
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
          tx_d     = tx_sh_q[tx_bit_q + 1'b1];
        end
      end
`ifdef UART_CORE_PARITY_EN
      PAR: if (tx_tick) begin
        tx_state_d = STOP;
        tx_bit_d   = '0;
        tx_d       = 1'b1;
      end
`endif
      STOP: if (tx_tick) begin
        if (tx_bit_q == BW'(STOP_BITS - 1)) begin
          tx_bit_d = '0;
          if (!empty) begin
            pop        = 1'b1;
            tx_sh_d    = mem_q[rd_q[AW-1:0]];
            tx_state_d = START;
            tx_d       = 1'b0;
          end else begin
            tx_state_d = IDLE;
            tx_d       = 1'b1;
          end
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end
      default: begin
        tx_state_d = IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  // ---------------- RX ----------------
  state_e               rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic                 rx_wait_q, rx_wait_d;
  logic                 rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d, rx_tick;

  assign rx_tick      = (rx_cnt_q == CW'(DIV - 1));
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_ferr_q;

`ifdef UART_CORE_PARITY_EN
  logic rx_ppend_q, rx_ppend_d, rx_perr_q, rx_perr_d;
  assign rx_parity_err = rx_perr_q;

  // Parity mismatch captured at the parity sample, reported with rx_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_ppend_q <= 1'b0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_ppend_q <= rx_ppend_d;
      rx_perr_q  <= rx_perr_d;
    end
  end
`else
  assign rx_parity_err = 1'b0;
`endif

  // Two-flop synchroniser plus one more stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // RX state register and output pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_wait_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_wait_q  <= rx_wait_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
    rx_sh_q <= rx_sh_d;
  end

  // RX next state: mid-bit sampling, glitch reject on start, first stop bit checked.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_tick ? '0 : rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_wait_d  = rx_wait_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
`ifdef UART_CORE_PARITY_EN
    rx_ppend_d = rx_ppend_q;
    rx_perr_d  = 1'b0;
`endif
    case (rx_state_q)
      IDLE: begin
        rx_cnt_d  = '0;
        rx_wait_d = 1'b0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = START;
      end
      START: if (rx_cnt_q == CW'(DIV / 2 - 1)) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? IDLE : DATA;
      end
      DATA: if (rx_tick) begin
        rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
        if (rx_bit_q == BW'(DATA_BITS - 1)) begin
          rx_bit_d = '0;
`ifdef UART_CORE_PARITY_EN
          rx_state_d = PAR_EN ? PAR : STOP;
`else
          rx_state_d = STOP;
`endif
        end else begin
          rx_bit_d = rx_bit_q + 1'b1;
        end
      end
`ifdef UART_CORE_PARITY_EN
      PAR: if (rx_tick) begin
        rx_ppend_d = rx_s2_q ^ par_bit(rx_sh_q);
        rx_state_d = STOP;
      end
`endif
      STOP: begin
        if (rx_wait_q) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            rx_wait_d  = 1'b0;
            rx_state_d = IDLE;
          end
        end else if (rx_tick) begin
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sh_q;
          rx_ferr_d  = !rx_s2_q;
`ifdef UART_CORE_PARITY_EN
          rx_perr_d  = PAR_EN && rx_ppend_q;
          rx_ppend_d = 1'b0;
`endif
          if (rx_s2_q) rx_state_d = IDLE;
          else         rx_wait_d  = 1'b1;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core (DIV = 10, 8 data bits, 1 stop bit, depth 4).
// Parity cases are exercised when UART_CORE_PARITY_EN is defined (PARITY = 2).
module tb_uart_core;
  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int DB     = 8;
  localparam int DEPTH  = 4;
`ifdef UART_CORE_PARITY_EN
  localparam int PAR = 2;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = DIV * (DB + 2 + ((PAR != 0) ? 1 : 0));

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx;
  logic       tx_ready, tx_busy, tx;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_parity_err;

  int n_chk = 0;
  int n_fail = 0;
  int orphan_err = 0;
  int perr_seen = 0;
  logic [9:0] rxq[$];
  logic       exp_q[$];
  logic [7:0] bytes [8];

  assign rx = loop_en ? tx : rx_drv;

  uart_core #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DB),
    .PARITY(PAR), .STOP_BITS(1), .TX_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_busy(tx_busy), .tx(tx), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference parity: even -> 1 when the payload has an odd number of ones.
  function automatic logic ref_par(input logic [7:0] b);
    logic odd_ones;
    odd_ones = ($countones(b) % 2) == 1;
    return (PAR == 1) ? !odd_ones : odd_ones;
  endfunction

  // Receive monitor: every rx_valid pulse recorded as {perr, ferr, data}.
  always @(negedge clk) begin
    if (rst_n && rx_valid) rxq.push_back({rx_parity_err, rx_frame_err, rx_data});
    if (rst_n && !rx_valid && (rx_frame_err || rx_parity_err)) orphan_err++;
    if (rx_parity_err) perr_seen++;
  end

  // Expected line waveform of one frame, one entry per clock.
  task automatic add_frame(input logic [7:0] b);
    repeat (DIV) exp_q.push_back(1'b0);
    for (int i = 0; i < DB; i++) repeat (DIV) exp_q.push_back(b[i]);
    if (PAR != 0) repeat (DIV) exp_q.push_back(ref_par(b));
    repeat (DIV) exp_q.push_back(1'b1);
  endtask

  // Push n bytes back-to-back and compare tx clock-by-clock with the model.
  task automatic run_tx(input int n, input string tag, output logic saw_full);
    int pushed, pos, bad_tx, bad_rdy, occ, start_lat, cyc;
    logic started, acc;
    exp_q.delete();
    for (int i = 0; i < n; i++) add_frame(bytes[i]);
    pushed = 0; pos = 0; bad_tx = 0; bad_rdy = 0; occ = 0;
    start_lat = -1; cyc = 0; started = 1'b0; saw_full = 1'b0;
    @(negedge clk);
    while (pos < exp_q.size() && cyc < n * FL + 50) begin
      tx_valid = (pushed < n);
      tx_data  = bytes[(pushed < n) ? pushed : 0];
      acc = tx_valid && tx_ready;
      if (tx_ready !== (occ < DEPTH)) bad_rdy++;
      if (!tx_ready) saw_full = 1'b1;
      @(negedge clk);
      cyc++;
      if (acc) begin pushed++; occ++; end
      if (!started && tx === 1'b0) begin started = 1'b1; start_lat = cyc; end
      if (started) begin
        if (pos % FL == 0) occ--;
        if (tx !== exp_q[pos]) bad_tx++;
        pos++;
      end
    end
    tx_valid = 1'b0;
    chk({tag, "_start_latency"}, start_lat, 2);
    chk({tag, "_all_pushed"}, pushed, n);
    chk({tag, "_frames_done"}, pos, exp_q.size());
    chk({tag, "_wave_errs"}, bad_tx, 0);
    chk({tag, "_ready_errs"}, bad_rdy, 0);
    @(negedge clk);
    chk({tag, "_busy_after"}, tx_busy, 0);
    chk({tag, "_tx_idle"}, tx, 1);
  endtask

  task automatic expect_rx(input string tag, input logic [7:0] d, input logic fe, input logic pe);
    logic [9:0] e;
    e = (rxq.size() > 0) ? rxq.pop_front() : {2'b11, ~d};
    chk({tag, "_data"}, e[7:0], d);
    chk({tag, "_ferr"}, e[8], fe);
    chk({tag, "_perr"}, e[9], pe);
  endtask

  // Bench-driven serial frame on rx (LSB first).
  task automatic drive_frame(input logic [7:0] b, input logic stop_v, input logic flip_par);
    rx_drv = 1'b0; repeat (DIV) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx_drv = b[i]; repeat (DIV) @(negedge clk);
    end
    if (PAR != 0) begin
      rx_drv = ref_par(b) ^ flip_par; repeat (DIV) @(negedge clk);
    end
    rx_drv = stop_v; repeat (DIV) @(negedge clk);
    rx_drv = 1'b1; repeat (2 * DIV) @(negedge clk);
  endtask

  initial begin
    logic full_seen;
    int n, lows, busys;

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_ferr", rx_frame_err, 0);
    chk("rst_rx_perr", rx_parity_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    bytes[0] = 8'hA5;
    run_tx(1, "a5", full_seen);
    chk("a5_never_full", full_seen, 0);

    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
    run_tx(5, "burst", full_seen);
    chk("burst_full_seen", full_seen, 1);

    loop_en = 1'b1;
    rxq.delete();
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
    run_tx(3, "loop", full_seen);
    repeat (2 * DIV) @(negedge clk);
    chk("loop_count", rxq.size(), 3);
    expect_rx("loop0", 8'h00, 1'b0, 1'b0);
    expect_rx("loop1", 8'hFF, 1'b0, 1'b0);
    expect_rx("loop2", 8'h3C, 1'b0, 1'b0);

    for (int it = 0; it < 3; it++) begin
      n = $urandom_range(2, 6);
      for (int i = 0; i < n; i++) bytes[i] = 8'($urandom);
      rxq.delete();
      run_tx(n, $sformatf("rnd%0d", it), full_seen);
      repeat (2 * DIV) @(negedge clk);
      chk($sformatf("rnd%0d_count", it), rxq.size(), n);
      for (int i = 0; i < n; i++) expect_rx($sformatf("rnd%0d_%0d", it, i), bytes[i], 1'b0, 1'b0);
    end
    loop_en = 1'b0;

    rxq.delete();
    rx_drv = 1'b0; repeat (3) @(negedge clk);
    rx_drv = 1'b1; repeat (3 * DIV) @(negedge clk);
    chk("glitch_no_valid", rxq.size(), 0);
    drive_frame(8'h55, 1'b1, 1'b0);
    chk("after_glitch_count", rxq.size(), 1);
    expect_rx("after_glitch", 8'h55, 1'b0, 1'b0);

    drive_frame(8'h12, 1'b0, 1'b0);
    chk("ferr_count", rxq.size(), 1);
    expect_rx("ferr", 8'h12, 1'b1, 1'b0);

`ifdef UART_CORE_PARITY_EN
    drive_frame(8'h07, 1'b1, 1'b1);
    chk("perr_count", rxq.size(), 1);
    expect_rx("perr", 8'h07, 1'b0, 1'b1);
`else
    chk("perr_tied_low", perr_seen, 0);
`endif
    chk("err_without_valid", orphan_err, 0);

    // Reset in the middle of a data bit with two more bytes queued.
    tx_valid = 1'b1; tx_data = 8'hA5;
    @(negedge clk); tx_data = 8'hB6;
    @(negedge clk); tx_data = 8'hC7;
    @(negedge clk); tx_valid = 1'b0;
    repeat (21) @(negedge clk);
    chk("rst_pre_tx_low", tx, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_tx_high", tx, 1);
    chk("midrst_busy", tx_busy, 0);
    chk("midrst_ready", tx_ready, 1);
    rst_n = 1'b1;
    lows = 0; busys = 0;
    repeat (3 * FL) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (tx_busy !== 1'b0) busys++;
    end
    chk("midrst_no_more_bits", lows, 0);
    chk("midrst_busy_stays_low", busys, 0);

    bytes[0] = 8'h5A;
    run_tx(1, "post_rst", full_seen);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
